// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - data-memory write checker against an expected-value table
module mem_write_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit REQUIRE_HALT   = 1'b0,
  localparam int IDX_W         = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [1:0]            fail_reason,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic [31:0]           cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  logic [NUM_CHECKS-1:0]   en_q, en_d;
  logic [NUM_CHECKS-1:0]   seen_q, seen_d;
  logic [ADDR_WIDTH-1:0]   addr_q [NUM_CHECKS];
  logic [ADDR_WIDTH-1:0]   addr_d [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   data_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   data_d [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   cap_q  [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]   cap_d  [NUM_CHECKS];
  logic [31:0]             cycles_q, cycles_d;
  logic                    timed_out_q, timed_out_d;
  logic [IDX_W-1:0]        chk_idx_q, chk_idx_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic [IDX_W-1:0]        fail_idx_q, fail_idx_d;
  logic [1:0]              fail_reason_q, fail_reason_d;
  logic [DATA_WIDTH-1:0]   fail_actual_q, fail_actual_d;

  logic [31:0]             cycles_inc;
  logic [1:0]              cand_reason;
  logic [DATA_WIDTH-1:0]   cand_actual;

  // State, table and result registers; reset clears everything and disables all entries
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      en_q          <= '0;
      seen_q        <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        cap_q[i]  <= '0;
      end
      cycles_q      <= '0;
      timed_out_q   <= 1'b0;
      chk_idx_q     <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_idx_q    <= '0;
      fail_reason_q <= '0;
      fail_actual_q <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      seen_q        <= seen_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      cap_q         <= cap_d;
      cycles_q      <= cycles_d;
      timed_out_q   <= timed_out_d;
      chk_idx_q     <= chk_idx_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      fail_idx_q    <= fail_idx_d;
      fail_reason_q <= fail_reason_d;
      fail_actual_q <= fail_actual_d;
    end
  end

  // Next-state: table config, write capture during RUN, and a one-entry-per-cycle CHECK sweep.
  // Reason codes are ordered by priority (11 > 10 > 01), so a numerically larger candidate
  // replaces the recorded one, while an equal one never does and the lowest index is kept.
  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    seen_d        = seen_q;
    addr_d        = addr_q;
    data_d        = data_q;
    cap_d         = cap_q;
    cycles_d      = cycles_q;
    timed_out_d   = timed_out_q;
    chk_idx_d     = chk_idx_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    fail_idx_d    = fail_idx_q;
    fail_reason_d = fail_reason_q;
    fail_actual_d = fail_actual_q;
    cand_reason   = 2'b00;
    cand_actual   = '0;
    cycles_inc    = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_we && (int'(cfg_idx) < NUM_CHECKS)) begin
          en_d[cfg_idx]   = cfg_en;
          addr_d[cfg_idx] = cfg_addr;
          data_d[cfg_idx] = cfg_data;
        end
        if (start) begin
          seen_d        = '0;
          for (int i = 0; i < NUM_CHECKS; i++) cap_d[i] = '0;
          cycles_d      = '0;
          timed_out_d   = 1'b0;
          chk_idx_d     = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          fail_idx_d    = '0;
          fail_reason_d = 2'b00;
          fail_actual_d = '0;
          state_d       = S_RUN;
        end
      end
      S_RUN: begin
        cycles_d  = cycles_inc;
        chk_idx_d = '0;
        if (mem_we) begin
          for (int i = 0; i < NUM_CHECKS; i++) begin
            if (en_q[i] && (addr_q[i] == mem_addr)) begin
              seen_d[i] = 1'b1;
              cap_d[i]  = mem_wdata;
            end
          end
        end
        if (halt) begin
          timed_out_d = 1'b0;
          state_d     = S_CHECK;
        end else if (cycles_inc >= TIMEOUT_W) begin
          timed_out_d = 1'b1;
          state_d     = S_CHECK;
          if (REQUIRE_HALT) fail_reason_d = 2'b11;
        end
      end
      S_CHECK: begin
        if (en_q[chk_idx_q]) begin
          if (!seen_q[chk_idx_q]) begin
            cand_reason = 2'b10;
          end else if (cap_q[chk_idx_q] != data_q[chk_idx_q]) begin
            cand_reason = 2'b01;
            cand_actual = cap_q[chk_idx_q];
          end
        end
        if (cand_reason > fail_reason_q) begin
          fail_reason_d = cand_reason;
          fail_idx_d    = chk_idx_q;
          fail_actual_d = cand_actual;
        end
        if (int'(chk_idx_q) == NUM_CHECKS - 1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (fail_reason_d == 2'b00);
          fail_d  = (fail_reason_d != 2'b00);
        end else begin
          chk_idx_d = chk_idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_idx    = fail_idx_q;
  assign fail_reason = fail_reason_q;
  assign fail_actual = fail_actual_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - randomized and directed bench for mem_write_checker
module tb_mem_write_checker;

  localparam int TMO = 20;
  localparam int NC  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic        o_busy [2];
  logic        o_done [2];
  logic        o_pass [2];
  logic        o_fail [2];
  logic [1:0]  o_idx [2];
  logic [1:0]  o_reason [2];
  logic [31:0] o_actual [2];
  logic [31:0] o_cycles [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference table and the writes of the current run
  bit          m_en [NC];
  logic [31:0] m_addr [NC];
  logic [31:0] m_data [NC];
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];

  // per-RUN-cycle write plan (index = RUN cycle, 1-based)
  bit          plan_we [32];
  logic [31:0] plan_addr [32];
  logic [31:0] plan_data [32];

  always #5 clk = ~clk;

  mem_write_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(NC),
                      .TIMEOUT_CYCLES(TMO), .REQUIRE_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .halt(halt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]),
    .fail_idx(o_idx[0]), .fail_reason(o_reason[0]), .fail_actual(o_actual[0]),
    .cycles(o_cycles[0]));

  mem_write_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHECKS(NC),
                      .TIMEOUT_CYCLES(TMO), .REQUIRE_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .halt(halt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]),
    .fail_idx(o_idx[1]), .fail_reason(o_reason[1]), .fail_actual(o_actual[1]),
    .cycles(o_cycles[1]));

  // Expected verdict from the rules: timeout under require-halt beats everything, then any
  // enabled entry never written (lowest index), then any entry whose last write differs.
  function automatic void model(input bit rh, input bit tmo, output bit e_pass,
                                output logic [1:0] e_idx, output logic [1:0] e_reason,
                                output logic [31:0] e_act);
    bit          seen [NC];
    logic [31:0] last [NC];
    e_pass = 1'b1; e_idx = '0; e_reason = '0; e_act = '0;
    for (int i = 0; i < NC; i++) begin
      seen[i] = 1'b0; last[i] = '0;
      for (int j = 0; j < wq_addr.size(); j++)
        if (wq_addr[j] == m_addr[i]) begin seen[i] = 1'b1; last[i] = wq_data[j]; end
    end
    if (rh && tmo) begin e_pass = 1'b0; e_reason = 2'b11; return; end
    for (int i = 0; i < NC; i++)
      if (e_pass && m_en[i] && !seen[i]) begin e_pass = 1'b0; e_idx = 2'(i); e_reason = 2'b10; end
    for (int i = 0; i < NC; i++)
      if (e_pass && m_en[i] && seen[i] && last[i] != m_data[i]) begin
        e_pass = 1'b0; e_idx = 2'(i); e_reason = 2'b01; e_act = last[i];
      end
  endfunction

  task automatic load(input int idx, input bit en, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    m_en[idx] = en; m_addr[idx] = a; m_data[idx] = d;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NC; i++) load(i, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 32; k++) begin plan_we[k] = 1'b0; plan_addr[k] = '0; plan_data[k] = '0; end
  endtask

  // One start..done run: halt on RUN cycle halt_at (outside 1..TMO means no halt).
  // With noise set, a table write and a start pulse are driven mid-RUN and must be ignored.
  task automatic run_check(input string name, input int halt_at, input bit noise);
    int end_k, cnt;
    bit tmo, e_pass;
    logic [1:0] e_idx, e_reason;
    logic [31:0] e_act;
    tmo   = !(halt_at >= 1 && halt_at <= TMO);
    end_k = tmo ? TMO : halt_at;
    wq_addr.delete(); wq_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= end_k; k++) begin
      mem_we = plan_we[k]; mem_addr = plan_addr[k]; mem_wdata = plan_data[k];
      halt = (k == halt_at);
      if (plan_we[k]) begin wq_addr.push_back(plan_addr[k]); wq_data.push_back(plan_data[k]); end
      if (noise && k == 2) begin
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_addr = 32'd84; cfg_data = 32'd12345;
        start = 1'b1;
      end
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
      if (k == 1) begin
        for (int d = 0; d < 2; d++) begin
          total_cnt++;
          if (o_busy[d] !== 1'b1 || o_done[d] !== 1'b0)
            $display("FAIL %s dut%0d run_status: busy=%0b done=%0b want busy=1 done=0", name, d, o_busy[d], o_done[d]);
          else pass_cnt++;
        end
      end
    end
    mem_we = 1'b0; halt = 1'b0;
    cnt = 0;
    while (!(o_done[0] && o_done[1]) && cnt < 20) begin @(negedge clk); cnt++; end
    total_cnt++;
    if (cnt != NC) $display("FAIL %s check_latency: got %0d cycles want %0d", name, cnt, NC);
    else pass_cnt++;
    for (int d = 0; d < 2; d++) begin
      model(d[0], tmo, e_pass, e_idx, e_reason, e_act);
      total_cnt++;
      if (o_done[d] !== 1'b1 || o_busy[d] !== 1'b0 || o_pass[d] !== e_pass || o_fail[d] !== !e_pass)
        $display("FAIL %s dut%0d status: done=%0b busy=%0b pass=%0b fail=%0b want done=1 busy=0 pass=%0b fail=%0b",
                 name, d, o_done[d], o_busy[d], o_pass[d], o_fail[d], e_pass, !e_pass);
      else pass_cnt++;
      total_cnt++;
      if (o_idx[d] !== e_idx || o_reason[d] !== e_reason || o_actual[d] !== e_act)
        $display("FAIL %s dut%0d result: idx=%0d reason=%b actual=%0d want idx=%0d reason=%b actual=%0d",
                 name, d, o_idx[d], o_reason[d], o_actual[d], e_idx, e_reason, e_act);
      else pass_cnt++;
      total_cnt++;
      if (o_cycles[d] !== 32'(end_k))
        $display("FAIL %s dut%0d cycles: got %0d want %0d", name, d, o_cycles[d], end_k);
      else pass_cnt++;
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      total_cnt++;
      if ({o_busy[d], o_done[d], o_pass[d], o_fail[d], o_idx[d], o_reason[d], o_actual[d], o_cycles[d]} !== '0)
        $display("FAIL %s dut%0d outputs: busy=%0b done=%0b pass=%0b fail=%0b idx=%0d reason=%b actual=%0d cycles=%0d want all 0",
                 name, d, o_busy[d], o_done[d], o_pass[d], o_fail[d], o_idx[d], o_reason[d], o_actual[d], o_cycles[d]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NC; i++) begin m_en[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
  endtask

  task automatic test_pass_basic();
    clear_plan(); load(0, 1'b1, 32'd84, 32'd7);
    plan_we[2] = 1'b1; plan_addr[2] = 32'd84; plan_data[2] = 32'd7;
    run_check("pass_basic", 5, 1'b0);
  endtask

  task automatic test_last_write_wins();
    clear_plan();
    plan_we[1] = 1'b1; plan_addr[1] = 32'd84; plan_data[1] = 32'd7;
    plan_we[3] = 1'b1; plan_addr[3] = 32'd84; plan_data[3] = 32'd9;
    run_check("last_write_wins", 5, 1'b0);
  endtask

  task automatic test_missing();
    clear_plan(); load(2, 1'b1, 32'd88, 32'd3);
    plan_we[2] = 1'b1; plan_addr[2] = 32'd84; plan_data[2] = 32'd7;
    run_check("missing_write", 6, 1'b0);
    load(2, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_timeout();
    clear_plan();
    plan_we[3] = 1'b1; plan_addr[3] = 32'd84; plan_data[3] = 32'd7;
    run_check("timeout", 0, 1'b0);
  endtask

  task automatic test_halt_coincident();
    clear_plan();
    plan_we[4] = 1'b1; plan_addr[4] = 32'd84; plan_data[4] = 32'd7;
    run_check("halt_with_write", 4, 1'b0);
    clear_plan();
    plan_we[TMO] = 1'b1; plan_addr[TMO] = 32'd84; plan_data[TMO] = 32'd7;
    run_check("halt_at_timeout", TMO, 1'b0);
  endtask

  task automatic test_cfg_ignored_in_run();
    clear_plan();
    plan_we[3] = 1'b1; plan_addr[3] = 32'd84; plan_data[3] = 32'd7;
    run_check("cfg_start_ignored", 5, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    mem_we = 1'b1; mem_addr = 32'd84; mem_wdata = 32'd7;
    repeat (5) @(negedge clk);
    mem_we = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("reset_mid_run");
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < NC; i++) begin m_en[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
    repeat (3) @(negedge clk);
    check_zero("after_reset_idle");
    clear_plan();
    run_check("rerun_empty_table", 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NC; i++)
        load(i, 1'($urandom_range(0, 1)), 32'd84 + 32'(4 * $urandom_range(0, 4)), 32'($urandom_range(0, 3)));
      clear_plan();
      for (int w = 0; w < int'($urandom_range(0, 8)); w++) begin
        int k;
        k = int'($urandom_range(1, 22));
        plan_we[k] = 1'b1;
        plan_addr[k] = 32'd84 + 32'(4 * $urandom_range(0, 4));
        plan_data[k] = 32'($urandom_range(0, 3));
      end
      run_check($sformatf("random_%0d", it), int'($urandom_range(1, 24)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_last_write_wins();
    test_missing();
    test_timeout();
    test_halt_coincident();
    test_cfg_ignored_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of monitored write data and expected values.
REQ-002 Parameter ADDR_WIDTH, default 32, width of monitored byte address.
REQ-003 Parameter NUM_CHECKS, default 4, number of expected-value table entries; IDX_W = max(1, clog2(NUM_CHECKS)).
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, maximum RUN cycles before forced end.
REQ-005 Parameter REQUIRE_HALT, default 0, 1 = a timeout is itself a failure.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 cfg_we  in  1  table write strobe.
REQ-009 cfg_idx  in  IDX_W  table entry index.
REQ-010 cfg_en  in  1  entry enable written with the entry.
REQ-011 cfg_addr / cfg_data  in  ADDR_WIDTH / DATA_WIDTH  expected address and value.
REQ-012 start  in  1  begin monitoring pulse.
REQ-013 halt  in  1  DUT end-of-program indication.
REQ-014 mem_we / mem_addr / mem_wdata  in  1 / ADDR_WIDTH / DATA_WIDTH  monitored data-memory write port.
REQ-015 busy, done, pass, fail  out  1 each  status.
REQ-016 fail_idx  out  IDX_W; fail_reason  out  2; fail_actual  out  DATA_WIDTH; cycles  out  32.

Function
REQ-017 FSM states: IDLE, RUN, CHECK, DONE.
REQ-018 cfg_we accepted only in IDLE or DONE; ignored in RUN/CHECK; out-of-range cfg_idx ignored.
REQ-019 start in IDLE or DONE: clears seen flags, captured values, cycles, and all result outputs; enters RUN. start ignored in RUN/CHECK.
REQ-020 RUN: busy=1; cycles increments every cycle, saturating at 2^32-1.
REQ-021 RUN: on mem_we, every enabled entry with cfg_addr == mem_addr (full-width compare) sets seen=1 and captures mem_wdata; later writes overwrite (last write wins).
REQ-022 RUN ends on halt, or when the RUN cycle count reaches TIMEOUT_CYCLES; a write sampled on the ending cycle is captured.
REQ-023 halt and timeout on the same cycle: halt wins, timed_out=0.
REQ-024 CHECK: evaluates one entry per cycle, index 0 to NUM_CHECKS-1; disabled entries pass; takes exactly NUM_CHECKS cycles, then DONE.
REQ-025 Failure priority: timed_out with REQUIRE_HALT=1 -> reason 2'b11, fail_idx=0; else lowest-index enabled entry with seen=0 -> reason 2'b10; else seen=1 and value != expected -> reason 2'b01, fail_actual = captured value.
REQ-026 Only the first failure by priority/index is reported; later failures do not overwrite.
REQ-027 DONE: done=1, busy=0; exactly one of pass/fail = 1, held until start or reset; no enabled entries -> pass=1.
REQ-028 fail_reason=2'b00, fail_idx=0, fail_actual=0 whenever pass=1.

Reset
REQ-029 reset low, asynchronously: state=IDLE; table entries disabled, cleared to 0; seen flags and cycles cleared; all outputs 0.
REQ-030 reset asserted mid-RUN or mid-CHECK aborts with no result; done stays 0 until a new completed run.
REQ-031 Reset deassertion takes effect on the next rising clk edge; no start accepted in the deassertion cycle.

Verification
REQ-032 Entry0 = {en=1, addr=84, data=7}; start; write 7 to 84; halt -> after NUM_CHECKS CHECK cycles done=1, pass=1, fail_reason=00.
REQ-033 Same entry; writes 7 then 9 to 84; halt -> fail=1, fail_idx=0, fail_reason=01, fail_actual=9.
REQ-034 Entry0 = {84, 7}, entry2 = {88, 3}; write 7 to 84 only; halt -> fail=1, fail_idx=2, reason=10.
REQ-035 REQUIRE_HALT=1, TIMEOUT_CYCLES=20, no halt -> cycles=20, fail=1, reason=11; same with REQUIRE_HALT=0 and 7 written to 84 -> pass=1.
REQ-036 halt and mem_we(84, 7) on the same cycle -> write captured, pass=1; halt coincident with the timeout cycle under REQUIRE_HALT=1 -> pass=1.
REQ-037 reset pulled low mid-RUN after 5 cycles -> outputs 0 immediately, table cleared; new start with no entries loaded -> pass=1.
